// File: rtl/fetch_stage.sv
// Instruction-fetch stage with F/D pipeline register and AdEL fetch-fault detection.
// Optional macro FETCH_RANGE_CHECK_EN adds an instruction-memory range check to the fault test.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        req,
  input  logic        eret_d,
  input  logic [31:0] epc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        is_jump_d,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [4:0]  d_exccode,
  output logic        d_bd
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0] r_pc;
  logic [31:0] r_d_instr;
  logic [31:0] r_d_pc;
  logic [4:0]  r_d_exccode;
  logic        r_d_bd;
  logic        w_fault;

`ifdef FETCH_RANGE_CHECK_EN
  logic w_out_of_range;
  assign w_out_of_range = (r_pc < 32'h0000_3000) || (r_pc > 32'h0000_6FFC);
  assign w_fault        = (r_pc[1:0] != 2'b00) || w_out_of_range;
`else
  assign w_fault = (r_pc[1:0] != 2'b00);
`endif

  // Priority: req > stall > eret > branch > sequential. A faulting fetch still advances the PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_d_instr   <= 32'h0;
      r_d_pc      <= RESET_PC;
      r_d_exccode <= EXC_NONE;
      r_d_bd      <= 1'b0;
    end else if (req) begin
      r_pc        <= HANDLER_PC;
      r_d_instr   <= 32'h0;
      r_d_pc      <= HANDLER_PC;
      r_d_exccode <= EXC_NONE;
      r_d_bd      <= 1'b0;
    end else if (!stall) begin
      if (eret_d) begin
        r_pc        <= epc;
        r_d_instr   <= 32'h0;
        r_d_pc      <= epc;
        r_d_exccode <= EXC_NONE;
        r_d_bd      <= 1'b0;
      end else begin
        r_pc        <= br_taken ? br_target : (r_pc + 32'd4);
        r_d_pc      <= r_pc;
        r_d_bd      <= is_jump_d;
        r_d_instr   <= w_fault ? 32'h0 : imem_rdata;
        r_d_exccode <= w_fault ? EXC_ADEL : EXC_NONE;
      end
    end
  end

  assign imem_addr = r_pc;
  assign d_instr   = r_d_instr;
  assign d_pc      = r_d_pc;
  assign d_exccode = r_d_exccode;
  assign d_bd      = r_d_bd;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall, branch, misaligned target,
// exception entry/eret, range check, PC wrap and asynchronous reset.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        req;
  logic        eret_d;
  logic [31:0] epc;
  logic        br_taken;
  logic [31:0] br_target;
  logic        is_jump_d;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic [4:0]  d_exccode;
  logic        d_bd;

  int total = 0;
  int bad   = 0;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .req        (req),
    .eret_d     (eret_d),
    .epc        (epc),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .is_jump_d  (is_jump_d),
    .d_instr    (d_instr),
    .d_pc       (d_pc),
    .d_exccode  (d_exccode),
    .d_bd       (d_bd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    stall = 0; req = 0; eret_d = 0; br_taken = 0; is_jump_d = 0;
    epc = 32'h0; br_target = 32'h0;
  endtask

  task automatic chk_bubble(input string tag, input logic [31:0] pc);
    chk({tag, "_instr"}, d_instr, 32'h0);
    chk({tag, "_pc"}, d_pc, pc);
    chk({tag, "_exc"}, {27'd0, d_exccode}, 32'd0);
    chk({tag, "_bd"}, {31'd0, d_bd}, 32'd0);
  endtask

  initial begin
    clear_ctl();
    imem_rdata = 32'h2408_0001;
    reset = 1;
    #12;
    chk("rst_addr", imem_addr, 32'h0000_3000);
    chk_bubble("rst", 32'h0000_3000);
    step();
    reset = 0;

    // Sequential fetch
    step();
    chk("seq0_pc", d_pc, 32'h0000_3000);
    chk("seq0_instr", d_instr, 32'h2408_0001);
    step();
    chk("seq1_pc", d_pc, 32'h0000_3004);
    imem_rdata = 32'h8C09_0004;
    step();
    chk("seq2_pc", d_pc, 32'h0000_3008);
    chk("seq2_instr", d_instr, 32'h8C09_0004);
    chk("seq2_addr", imem_addr, 32'h0000_300C);
    chk("seq2_exc", {27'd0, d_exccode}, 32'd0);
    imem_rdata = 32'h0000_0001;
    step();
    chk("seq3_pc", d_pc, 32'h0000_300C);
    chk("seq3_addr", imem_addr, 32'h0000_3010);

    // Stall two cycles at 3010
    stall = 1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    chk("stall0_addr", imem_addr, 32'h0000_3010);
    chk("stall0_pc", d_pc, 32'h0000_300C);
    chk("stall0_instr", d_instr, 32'h0000_0001);
    br_taken = 1; br_target = 32'h0000_5000; eret_d = 1; epc = 32'h0000_5555;
    step();
    chk("stall1_addr", imem_addr, 32'h0000_3010);
    chk("stall1_pc", d_pc, 32'h0000_300C);
    clear_ctl();
    imem_rdata = 32'h1234_5678;
    step();
    chk("unstall_pc", d_pc, 32'h0000_3010);
    chk("unstall_instr", d_instr, 32'h1234_5678);
    chk("unstall_addr", imem_addr, 32'h0000_3014);

    // Taken branch with delay slot
    br_taken = 1; br_target = 32'h0000_3100; is_jump_d = 1;
    step();
    chk("br_pc", d_pc, 32'h0000_3014);
    chk("br_bd", {31'd0, d_bd}, 32'd1);
    chk("br_addr", imem_addr, 32'h0000_3100);
    clear_ctl();
    step();
    chk("tgt_pc", d_pc, 32'h0000_3100);
    chk("tgt_bd", {31'd0, d_bd}, 32'd0);

    // Misaligned target faults with AdEL
    br_taken = 1; br_target = 32'h0000_3102; is_jump_d = 1;
    step();
    chk("mis_addr", imem_addr, 32'h0000_3102);
    clear_ctl();
    step();
    chk("mis_instr", d_instr, 32'h0);
    chk("mis_exc", {27'd0, d_exccode}, 32'd4);
    chk("mis_pc", d_pc, 32'h0000_3102);
    chk("mis_adv", imem_addr, 32'h0000_3106);

    // Realign and reach 3020
    br_taken = 1; br_target = 32'h0000_3020;
    step();
    clear_ctl();
    chk("pre_req_addr", imem_addr, 32'h0000_3020);

    // req overrides stall, eret and branch
    req = 1; stall = 1; eret_d = 1; epc = 32'h0000_3024; br_taken = 1; br_target = 32'h0000_3300;
    step();
    chk("req_addr", imem_addr, 32'h0000_4180);
    chk_bubble("req", 32'h0000_4180);

    // stall suppresses eret
    clear_ctl();
    stall = 1; eret_d = 1; epc = 32'h0000_3024;
    step();
    chk("eret_stall_addr", imem_addr, 32'h0000_4180);
    stall = 0;
    step();
    chk("eret_addr", imem_addr, 32'h0000_3024);
    chk_bubble("eret", 32'h0000_3024);
    clear_ctl();
    imem_rdata = 32'hAABB_CCDD;
    step();
    chk("post_eret_pc", d_pc, 32'h0000_3024);
    chk("post_eret_instr", d_instr, 32'hAABB_CCDD);

    // Range check at 7000
    br_taken = 1; br_target = 32'h0000_7000;
    step();
    clear_ctl();
    imem_rdata = 32'h0102_0304;
    step();
    chk("rng_pc", d_pc, 32'h0000_7000);
`ifdef FETCH_RANGE_CHECK_EN
    chk("rng_exc", {27'd0, d_exccode}, 32'd4);
    chk("rng_instr", d_instr, 32'h0);
`else
    chk("rng_exc", {27'd0, d_exccode}, 32'd0);
    chk("rng_instr", d_instr, 32'h0102_0304);
`endif

    // Upper in-range boundary 6FFC never faults
    br_taken = 1; br_target = 32'h0000_6FFC;
    step();
    clear_ctl();
    step();
    chk("hi_ok_exc", {27'd0, d_exccode}, 32'd0);
    chk("hi_ok_instr", d_instr, 32'h0102_0304);

    // PC wraps modulo 2^32
    br_taken = 1; br_target = 32'hFFFF_FFFC;
    step();
    clear_ctl();
    step();
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    chk("wrap_pc", d_pc, 32'hFFFF_FFFC);

    // Asynchronous reset between edges
    #3;
    reset = 1;
    #1;
    chk("arst_addr", imem_addr, 32'h0000_3000);
    chk_bubble("arst", 32'h0000_3000);
    step();
    reset = 0;
    imem_rdata = 32'h2408_0001;
    step();
    chk("arst_first_pc", d_pc, 32'h0000_3000);
    chk("arst_first_instr", d_instr, 32'h2408_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
